// File: rtl/rx_fifo_write_arbiter_if.sv
// Sample-source and FIFO write-side bundle for rx_fifo_write_arbiter.
// The arbiter uses the slave modport; a source/FIFO model uses master.
interface rx_fifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s0_tdata;
  logic                  s0_tvalid;
  logic                  s0_tready;
  logic [DATA_WIDTH-1:0] s1_tdata;
  logic                  s1_tvalid;
  logic                  s1_tready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;

  modport slave (
    input  s0_tdata, s0_tvalid, s1_tdata, s1_tvalid, fifo_full,
    output s0_tready, s1_tready, fifo_wr_en, fifo_wr_data
  );

  modport master (
    output s0_tdata, s0_tvalid, s1_tdata, s1_tvalid, fifo_full,
    input  s0_tready, s1_tready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/rx_fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between two sample sources.
// Optional RX_ARB_STATS_EN adds per-source word counters and a stall counter.
module rx_fifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  arb_enable,
  rx_fifo_write_arbiter_if.slave bus,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  words_total,
  output logic [CNT_WIDTH-1:0]  s0_words,
  output logic [CNT_WIDTH-1:0]  s1_words,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t                r_state;
  logic                  r_rr_ptr;
  logic [7:0]            r_beat_cnt;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [CNT_WIDTH-1:0]  r_words_total;

  logic                  w_g0;
  logic                  w_g1;
  logic                  w_ready0;
  logic                  w_ready1;
  logic                  w_beat0;
  logic                  w_beat1;
  logic                  w_beat;
  logic                  w_src_valid;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  w_release;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  assign w_g0     = (r_state == GRANT0);
  assign w_g1     = (r_state == GRANT1);
  assign w_ready0 = w_g0 & arb_enable & ~bus.fifo_full;
  assign w_ready1 = w_g1 & arb_enable & ~bus.fifo_full;
  assign w_beat0  = w_ready0 & bus.s0_tvalid;
  assign w_beat1  = w_ready1 & bus.s1_tvalid;
  assign w_beat   = w_beat0 | w_beat1;

  assign w_src_valid = w_g1 ? bus.s1_tvalid : bus.s0_tvalid;
  assign w_src_data  = w_g1 ? bus.s1_tdata  : bus.s0_tdata;

  // A release (disable, idle source, or final beat) always ends the grant;
  // with fifo_full asserted the first two still release, just without a write.
  assign w_release = (w_g0 | w_g1) &
                     (~arb_enable | ~w_src_valid | (w_beat & (r_beat_cnt == LAST_BEAT)));

  assign bus.s0_tready    = w_ready0;
  assign bus.s1_tready    = w_ready1;
  assign bus.fifo_wr_en   = w_beat;
  assign bus.fifo_wr_data = w_beat ? w_src_data : r_wr_data;
  assign grant            = {w_g1, w_g0};
  assign words_total      = r_words_total;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_beat_cnt <= '0;
          if (arb_enable && (bus.s0_tvalid || bus.s1_tvalid)) begin
            if (bus.s0_tvalid && (!bus.s1_tvalid || !r_rr_ptr)) begin
              r_state  <= GRANT0;
              r_rr_ptr <= 1'b1;
            end else begin
              r_state  <= GRANT1;
              r_rr_ptr <= 1'b0;
            end
          end
        end
        GRANT0, GRANT1: begin
          if (w_release) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_data     <= '0;
      r_words_total <= '0;
    end else begin
      if (w_beat) r_wr_data <= w_src_data;
      r_words_total <= sat_inc(r_words_total, w_beat);
    end
  end

`ifdef RX_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] r_s0_words;
  logic [CNT_WIDTH-1:0] r_s1_words;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic                 w_stall;

  assign w_stall = bus.fifo_full & arb_enable &
                   ((w_g0 & bus.s0_tvalid) | (w_g1 & bus.s1_tvalid));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_s0_words     <= '0;
      r_s1_words     <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_s0_words     <= sat_inc(r_s0_words, w_beat0);
      r_s1_words     <= sat_inc(r_s1_words, w_beat1);
      r_stall_cycles <= sat_inc(r_stall_cycles, w_stall);
    end
  end

  assign s0_words     = r_s0_words;
  assign s1_words     = r_s1_words;
  assign stall_cycles = r_stall_cycles;
`else
  assign s0_words     = '0;
  assign s1_words     = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rx_fifo_write_arbiter.sv
// Self-checking bench for rx_fifo_write_arbiter: cycle vector table plus
// streaming, contention, backpressure and saturation sequences.
module tb_rx_fifo_write_arbiter;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic arb_enable = 1'b0;

  always #5 ACLK = ~ACLK;

  rx_fifo_write_arbiter_if #(.DATA_WIDTH(32)) bus ();
  rx_fifo_write_arbiter_if #(.DATA_WIDTH(32)) bus_sat ();

  logic [1:0]  grant, sat_grant;
  logic [15:0] words_total, s0_words, s1_words, stall_cycles;
  logic [3:0]  sat_total, sat_s0, sat_s1, sat_stall;

  rx_fifo_write_arbiter #(.DATA_WIDTH(32), .BURST_LEN(8), .CNT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .arb_enable(arb_enable), .bus(bus),
    .grant(grant), .words_total(words_total), .s0_words(s0_words),
    .s1_words(s1_words), .stall_cycles(stall_cycles)
  );

  // Narrow-counter copy sees exactly the same stimulus.
  assign bus_sat.s0_tdata  = bus.s0_tdata;
  assign bus_sat.s0_tvalid = bus.s0_tvalid;
  assign bus_sat.s1_tdata  = bus.s1_tdata;
  assign bus_sat.s1_tvalid = bus.s1_tvalid;
  assign bus_sat.fifo_full = bus.fifo_full;

  rx_fifo_write_arbiter #(.DATA_WIDTH(32), .BURST_LEN(8), .CNT_WIDTH(4)) dut_sat (
    .ACLK(ACLK), .ARESETN(ARESETN), .arb_enable(arb_enable), .bus(bus_sat),
    .grant(sat_grant), .words_total(sat_total), .s0_words(sat_s0),
    .s1_words(sat_s1), .stall_cycles(sat_stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    arb_enable = 1'b0;
    bus.s0_tvalid = 1'b0;
    bus.s1_tvalid = 1'b0;
    bus.fifo_full = 1'b0;
    bus.s0_tdata = '0;
    bus.s1_tdata = '0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       v0;
    logic       v1;
    logic       full;
    logic [1:0] grant;
    logic       rdy0;
    logic       rdy1;
    logic       wr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] exp_data;
    int          exp_total;
    logic [31:0] s0d, s1d;

    bus.s0_tvalid = 1'b0;
    bus.s1_tvalid = 1'b0;
    bus.fifo_full = 1'b0;
    bus.s0_tdata  = '0;
    bus.s1_tdata  = '0;

    //          rst en v0 v1 full  grant  rdy0 rdy1 wr
    vecs[0]  = '{0, 1, 1, 1, 0, 2'b00, 0, 0, 0};  // reset with both valid
    vecs[1]  = '{1, 1, 0, 1, 0, 2'b00, 0, 0, 0};  // IDLE, s1 alone requests
    vecs[2]  = '{1, 1, 0, 1, 0, 2'b10, 0, 1, 1};
    vecs[3]  = '{1, 1, 0, 1, 0, 2'b10, 0, 1, 1};
    vecs[4]  = '{1, 1, 0, 1, 1, 2'b10, 0, 0, 0};  // full: held, no write
    vecs[5]  = '{1, 1, 1, 1, 0, 2'b10, 0, 1, 1};  // third s1 beat
    vecs[6]  = '{1, 0, 1, 1, 0, 2'b10, 0, 0, 0};  // disable: ready drops same cycle
    vecs[7]  = '{1, 0, 1, 1, 0, 2'b00, 0, 0, 0};  // disabled: no new grant
    vecs[8]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0};  // both valid, rr favours s0
    vecs[9]  = '{1, 1, 1, 1, 1, 2'b01, 0, 0, 0};
    vecs[10] = '{1, 1, 0, 1, 1, 2'b01, 0, 0, 0};  // full + source idle: release, no write
    vecs[11] = '{1, 1, 0, 1, 0, 2'b00, 0, 0, 0};
    vecs[12] = '{1, 1, 0, 0, 0, 2'b10, 0, 1, 0};  // granted but source idle
    vecs[13] = '{1, 1, 0, 0, 0, 2'b00, 0, 0, 0};
    vecs[14] = '{1, 1, 1, 0, 0, 2'b00, 0, 0, 0};
    vecs[15] = '{1, 1, 1, 0, 0, 2'b01, 1, 0, 1};
    vecs[16] = '{0, 1, 1, 0, 0, 2'b00, 0, 0, 0};  // async reset mid-burst
    vecs[17] = '{1, 1, 0, 0, 0, 2'b00, 0, 0, 0};

    exp_data  = '0;
    exp_total = 0;
    for (int i = 0; i < 18; i++) begin
      @(posedge ACLK); #1;
      s0d = 32'hA0A0_0000 + 32'(i);
      s1d = 32'hB0B0_0000 + 32'(i);
      ARESETN       = vecs[i].rst_n;
      arb_enable    = vecs[i].en;
      bus.s0_tvalid = vecs[i].v0;
      bus.s1_tvalid = vecs[i].v1;
      bus.fifo_full = vecs[i].full;
      bus.s0_tdata  = s0d;
      bus.s1_tdata  = s1d;
      @(negedge ACLK);
      if (!vecs[i].rst_n) begin
        exp_data  = '0;
        exp_total = 0;
      end
      check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
      check($sformatf("v%0d s0_tready", i), 32'(bus.s0_tready), 32'(vecs[i].rdy0));
      check($sformatf("v%0d s1_tready", i), 32'(bus.s1_tready), 32'(vecs[i].rdy1));
      check($sformatf("v%0d fifo_wr_en", i), 32'(bus.fifo_wr_en), 32'(vecs[i].wr));
      check($sformatf("v%0d words_total", i), 32'(words_total), 32'(exp_total));
      if (vecs[i].wr) exp_data = (vecs[i].grant == 2'b01) ? s0d : s1d;
      check($sformatf("v%0d fifo_wr_data", i), bus.fifo_wr_data, exp_data);
      if (vecs[i].wr) exp_total++;
      if (i == 13) begin
`ifdef RX_ARB_STATS_EN
        check("table s0_words", 32'(s0_words), 32'd0);
        check("table s1_words", 32'(s1_words), 32'd3);
        check("table stall_cycles", 32'(stall_cycles), 32'd2);
`else
        check("table s1_words tied", 32'(s1_words), 32'd0);
        check("table stall tied", 32'(stall_cycles), 32'd0);
`endif
      end
    end

    // Single source streams 1..20: bursts 8,8,4 with one-cycle bubbles.
    begin
      int bursts[$];
      int gaps[$];
      int exp_bursts[3];
      int cur, gap, sent;
      logic done, beat;
      logic [31:0] exp_next;
      exp_bursts = '{8, 8, 4};
      do_reset();
      bus.s0_tdata  = 32'd1;
      bus.s0_tvalid = 1'b1;
      arb_enable    = 1'b1;
      cur = 0; gap = 0; sent = 0; done = 1'b0; exp_next = 32'd1;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge ACLK);
        beat = bus.fifo_wr_en;
        if (beat) begin
          check("stream data", bus.fifo_wr_data, exp_next);
          exp_next++;
          if (cur == 0 && sent > 0) gaps.push_back(gap);
          cur++; sent++; gap = 0;
        end else begin
          if (cur > 0) begin
            bursts.push_back(cur);
            cur = 0;
          end
          gap++;
          if (sent == 20) done = 1'b1;
        end
        @(posedge ACLK); #1;
        if (beat) begin
          if (bus.s0_tdata == 32'd20) bus.s0_tvalid = 1'b0;
          else bus.s0_tdata = bus.s0_tdata + 32'd1;
        end
      end
      check("stream finished in budget", 32'(done), 32'd1);
      check("stream burst count", 32'(bursts.size()), 32'd3);
      for (int k = 0; k < 3; k++)
        check($sformatf("stream burst %0d len", k),
              (k < bursts.size()) ? 32'(bursts[k]) : 32'hFFFF_FFFF, 32'(exp_bursts[k]));
      check("stream gap count", 32'(gaps.size()), 32'd2);
      for (int k = 0; k < 2; k++)
        check($sformatf("stream gap %0d", k),
              (k < gaps.size()) ? 32'(gaps[k]) : 32'hFFFF_FFFF, 32'd1);
      check("stream words_total", 32'(words_total), 32'd20);
      check("saturated words_total", 32'(sat_total), 32'hF);
`ifdef RX_ARB_STATS_EN
      check("stream s0_words", 32'(s0_words), 32'd20);
      check("saturated s0_words", 32'(sat_s0), 32'hF);
`else
      check("stream s0_words tied", 32'(s0_words), 32'd0);
`endif
      arb_enable = 1'b0;
    end

    // Both sources always valid: alternating 8-beat bursts separated by IDLE.
    begin
      int run_g[16];
      int run_n[16];
      int nrun;
      int exp_g[7];
      int exp_n[7];
      exp_g = '{0, 1, 0, 2, 0, 1, 0};
      exp_n = '{1, 8, 1, 8, 1, 8, 1};
      do_reset();
      bus.s0_tdata  = 32'h0000_0100;
      bus.s1_tdata  = 32'h0000_0200;
      bus.s0_tvalid = 1'b1;
      bus.s1_tvalid = 1'b1;
      arb_enable    = 1'b1;
      nrun = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge ACLK);
        if (nrun > 0 && run_g[nrun-1] == int'(grant)) run_n[nrun-1] += 1;
        else if (nrun < 16) begin
          run_g[nrun] = int'(grant);
          run_n[nrun] = 1;
          nrun++;
        end
        if (c == 12) check("contention s1 data", bus.fifo_wr_data, 32'h0000_0200);
        @(posedge ACLK); #1;
      end
      for (int k = 0; k < 7; k++) begin
        check($sformatf("contention run %0d grant", k),
              (k < nrun) ? 32'(run_g[k]) : 32'hFFFF_FFFF, 32'(exp_g[k]));
        check($sformatf("contention run %0d length", k),
              (k < nrun) ? 32'(run_n[k]) : 32'hFFFF_FFFF, 32'(exp_n[k]));
      end
      bus.s0_tvalid = 1'b0;
      bus.s1_tvalid = 1'b0;
    end

    // Backpressure: fifo_full for 5 cycles after 3 beats of an s0 burst.
    begin
      int gcyc, beats, full_writes;
      logic done;
      do_reset();
      bus.s0_tdata  = 32'h0000_0077;
      bus.s0_tvalid = 1'b1;
      arb_enable    = 1'b1;
      gcyc = 0; beats = 0; full_writes = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        @(negedge ACLK);
        if (grant == 2'b01) begin
          gcyc++;
          if (bus.fifo_wr_en) beats++;
          if (bus.fifo_full && bus.fifo_wr_en) full_writes++;
        end else if (gcyc > 0) begin
          done = 1'b1;
        end
        @(posedge ACLK); #1;
        bus.fifo_full = (gcyc >= 3 && gcyc < 8);
      end
      check("backpressure finished in budget", 32'(done), 32'd1);
      check("backpressure granted cycles", 32'(gcyc), 32'd13);
      check("backpressure beats", 32'(beats), 32'd8);
      check("backpressure writes while full", 32'(full_writes), 32'd0);
      check("backpressure words_total", 32'(words_total), 32'd8);
`ifdef RX_ARB_STATS_EN
      check("backpressure stall_cycles", 32'(stall_cycles), 32'd5);
`else
      check("backpressure stall tied", 32'(stall_cycles), 32'd0);
`endif
      bus.s0_tvalid = 1'b0;
      bus.fifo_full = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
